// File: rtl/fft_frame_collector.sv
// fft_frame_collector
//   Upstream feeder for the 16-point FFT. Kept samples are scaled and collected into
//   a 16-slot fill buffer. Each completed frame is copied into the t_bus hold register
//   and handed to the FFT with a one-cycle new_t pulse, which is gated by fft_done.
//   Sampling continues while a frame waits in the hold register.
//
//   Parameters: DECIM (1..256) keep every DECIM-th valid sample,
//               GAIN_SHIFT (0..15) arithmetic right shift per kept sample,
//               DROP_CNT_W width of the saturating drop counter.
//   Build option: define BITREV_EN to write kept sample k into slot bitrev4(k)
//                 (decimation-in-time order); otherwise slot k.
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     sample_in/_valid    signed 16-bit sample stream, no backpressure
//     fft_done            FFT idle; the FFT loads a frame on new_t & fft_done
//     clr_overrun         synchronous clear of overrun and drop_cnt
//     t_bus               frame to FFT, slot k at [16k+15:16k]
//     new_t               one-cycle frame-issue pulse
//     sample_ready        high while collecting (state FILL)
//     frame_cnt           frames issued (wrapping)
//     overrun, drop_cnt   sticky drop flag and saturating count of dropped samples
module fft_frame_collector #(
  parameter int unsigned DECIM      = 1,
  parameter int unsigned GAIN_SHIFT = 0,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           sample_in,
  input  logic                  sample_valid,
  input  logic                  fft_done,
  input  logic                  clr_overrun,
  output logic [255:0]          t_bus,
  output logic                  new_t,
  output logic                  sample_ready,
  output logic [15:0]           frame_cnt,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [7:0] LP_DEC_LAST = 8'(DECIM - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_dec_cnt;
  logic [3:0]            r_wr_idx;
  logic [15:0]           r_fill [16];
  logic [255:0]          r_t_bus;
  logic                  r_new_t;
  logic                  r_pending;
  logic [15:0]           r_frame_cnt;
  logic                  r_overrun;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_kept;
  logic                  w_copy_ok;
  logic                  w_issue;
  logic                  w_write;
  logic                  w_copy;
  logic                  w_drop;
  logic [3:0]            w_slot;
  logic signed [15:0]    w_scaled;
  logic [255:0]          w_frame;

  assign w_kept    = sample_valid && (r_dec_cnt == '0);
  assign w_scaled  = $signed(sample_in) >>> GAIN_SHIFT;
  // The hold register may only be overwritten once the previous frame has been
  // issued and its new_t cycle is over, so t_bus is stable while new_t is high.
  assign w_copy_ok = !r_pending && !r_new_t;
  assign w_issue   = r_pending && fft_done && !r_new_t;

`ifdef BITREV_EN
  assign w_slot = {r_wr_idx[0], r_wr_idx[1], r_wr_idx[2], r_wr_idx[3]};
`else
  assign w_slot = r_wr_idx;
`endif

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_copy      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_kept) begin
          w_write = 1'b1;
          if (r_wr_idx == 4'd15) begin
            if (w_copy_ok) begin
              w_copy = 1'b1;
            end else begin
              w_state_nxt = FULL;
            end
          end
        end
      end
      FULL: begin
        w_drop = w_kept;
        if (w_copy_ok) begin
          w_copy      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Frame presented to the hold register: the fill buffer with this cycle's
  // write merged in, so the slot-15 sample is captured on the same edge.
  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      w_frame[16*k +: 16] = r_fill[k];
    end
    if (w_write) begin
      w_frame[{w_slot, 4'b0000} +: 16] = w_scaled;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill storage needs no reset: every frame writes all 16 slots before a copy.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_fill[w_slot] <= w_scaled;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt   <= '0;
      r_wr_idx    <= '0;
      r_t_bus     <= '0;
      r_pending   <= 1'b0;
      r_new_t     <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (sample_valid) begin
        r_dec_cnt <= (r_dec_cnt == LP_DEC_LAST) ? '0 : r_dec_cnt + 8'd1;
      end

      if (w_copy) begin
        r_wr_idx <= '0;
      end else if (w_write) begin
        r_wr_idx <= r_wr_idx + 4'd1;
      end

      if (w_copy) begin
        r_t_bus <= w_frame;
      end

      // copy needs !pending and issue needs pending, so they never coincide
      if (w_copy) begin
        r_pending <= 1'b1;
      end else if (w_issue) begin
        r_pending <= 1'b0;
      end

      if (r_new_t) begin
        r_new_t     <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (w_issue) begin
        r_new_t <= 1'b1;
      end

      if (clr_overrun) begin
        r_overrun  <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
      end
    end
  end

  assign t_bus        = r_t_bus;
  assign new_t        = r_new_t;
  assign sample_ready = (r_state == FILL);
  assign frame_cnt    = r_frame_cnt;
  assign overrun      = r_overrun;
  assign drop_cnt     = r_drop_cnt;

endmodule
